// File: rtl/rca_pkg.sv
// Shared types and helpers for the streaming multi-operand adder.
// Holds the accumulate FSM state type and the wrap/saturate add.
package rca_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } acc_state_e;

  localparam int MAX_W = 64;

  typedef struct packed {
    logic             carry;
    logic [MAX_W-1:0] sum;
  } add_res_t;

  function automatic int min_out_w(
    input int w,
    input int n
  );
    return w + $clog2(n);
  endfunction

  // w-bit add; carry is bit w of the result.
  // Saturation clamps to all-ones on carry.
  function automatic add_res_t sat_add(
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input int unsigned      w,
    input logic             sat
  );
    logic [MAX_W:0] t;
    logic [MAX_W:0] m;
    add_res_t       r;
    t = {1'b0, a} + {1'b0, b};
    m = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
    r.carry = |(t & ~m);
    if (sat && r.carry) r.sum = m[MAX_W-1:0];
    else r.sum = t[MAX_W-1:0] & m[MAX_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/rca_sum_stage.sv
// Combinational NUM_OPS x WIDTH adder, zero-extended to OUT_W.
// OUT_W is wide enough that the sum never overflows.
import rca_pkg::*;

module rca_sum_stage #(
  parameter int WIDTH   = 8,
  parameter int NUM_OPS = 3,
  parameter int OUT_W   = 11
) (
  input  logic [NUM_OPS*WIDTH-1:0] i_ops,
  output logic [OUT_W-1:0]         o_sum
);

  always_comb begin
    o_sum = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      o_sum = o_sum + OUT_W'(i_ops[i*WIDTH +: WIDTH]);
    end
  end

endmodule

// File: rtl/rca_accum_pipe.sv
// Two-stage streaming adder: S1 sums a beat, S2 emits it or
// folds a packet into a wrap/saturate accumulator.
import rca_pkg::*;

module rca_accum_pipe #(
  parameter int WIDTH   = 8,
  parameter int NUM_OPS = 3,
  parameter int OUT_W   = 11,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_OPS*WIDTH-1:0] in_ops,
  input  logic                     in_last,
  input  logic                     cfg_acc,
  input  logic                     cfg_sat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_sum,
  output logic                     out_ovf,
  output logic [CNT_W-1:0]         out_count,
  output logic                     busy
);

  localparam int MIN_W = min_out_w(WIDTH, NUM_OPS);

  if (OUT_W < MIN_W || OUT_W >= MAX_W || NUM_OPS < 2) begin : g_bad
    $error("rca_accum_pipe: OUT_W too small or NUM_OPS < 2");
  end

  logic [OUT_W-1:0] w_beat_sum;
  logic             w_busy;
  logic             w_s2_go;
  logic             w_in_rdy;
  logic             w_accept;
  logic             w_mode_acc;
  logic             w_mode_sat;
  add_res_t         w_add;
  logic [OUT_W-1:0] w_acc_nx;
  logic             w_ovf_nx;
  logic [CNT_W-1:0] w_cnt_inc;

  logic             r_s1_valid;
  logic [OUT_W-1:0] r_s1_sum;
  logic             r_s1_last;
  logic             r_s1_acc;
  logic             r_s1_sat;
  logic             r_act_acc;
  logic             r_act_sat;

  acc_state_e       r_state;
  logic [OUT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_sum;
  logic             r_out_ovf;
  logic [CNT_W-1:0] r_out_count;

  rca_sum_stage #(
    .WIDTH   (WIDTH),
    .NUM_OPS (NUM_OPS),
    .OUT_W   (OUT_W)
  ) u_sum (
    .i_ops (in_ops),
    .o_sum (w_beat_sum)
  );

  assign w_busy   = r_s1_valid | r_out_valid | (r_state == RUN);
  assign w_s2_go  = !r_out_valid || out_ready;
  assign w_in_rdy = rst_n && (!r_s1_valid || w_s2_go);
  assign w_accept = in_valid && w_in_rdy;

  // Mode is frozen while anything is in flight.
  assign w_mode_acc = w_busy ? r_act_acc : cfg_acc;
  assign w_mode_sat = w_busy ? r_act_sat : cfg_sat;

  assign w_add = sat_add(MAX_W'(r_acc), MAX_W'(r_s1_sum),
                         OUT_W, r_s1_sat);
  assign w_acc_nx  = w_add.sum[OUT_W-1:0];
  assign w_ovf_nx  = r_ovf | w_add.carry;
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_last  <= 1'b0;
      r_s1_acc   <= 1'b0;
      r_s1_sat   <= 1'b0;
      r_act_acc  <= 1'b0;
      r_act_sat  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_sum   <= w_beat_sum;
        r_s1_last  <= in_last;
        r_s1_acc   <= w_mode_acc;
        r_s1_sat   <= w_mode_sat;
      end else if (w_s2_go) begin
        r_s1_valid <= 1'b0;
      end
      if (w_accept && !w_busy) begin
        r_act_acc <= cfg_acc;
        r_act_sat <= cfg_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
      r_out_count <= '0;
    end else if (w_s2_go) begin
      r_out_valid <= 1'b0;
      if (r_s1_valid) begin
        if (!r_s1_acc) begin
          r_out_valid <= 1'b1;
          r_out_sum   <= r_s1_sum;
          r_out_ovf   <= 1'b0;
          r_out_count <= CNT_W'(1);
        end else begin
          unique case (r_state)
            IDLE: begin
              r_acc <= r_s1_sum;
              r_cnt <= CNT_W'(1);
              r_ovf <= 1'b0;
              if (r_s1_last) begin
                r_out_valid <= 1'b1;
                r_out_sum   <= r_s1_sum;
                r_out_ovf   <= 1'b0;
                r_out_count <= CNT_W'(1);
              end else begin
                r_state <= RUN;
              end
            end
            RUN: begin
              r_acc <= w_acc_nx;
              r_cnt <= w_cnt_inc;
              r_ovf <= w_ovf_nx;
              if (r_s1_last) begin
                r_out_valid <= 1'b1;
                r_out_sum   <= w_acc_nx;
                r_out_ovf   <= w_ovf_nx;
                r_out_count <= w_cnt_inc;
                r_state     <= IDLE;
              end
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

  assign in_ready  = w_in_rdy;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_ovf   = r_out_ovf;
  assign out_count = r_out_count;
  assign busy      = w_busy;

endmodule

// File: tb/tb_rca_accum_pipe.sv
// Directed-vector bench for rca_accum_pipe (default parameters).
// Inputs change on negedge; outputs are sampled on negedge.
module tb_rca_accum_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_ops;
  logic        in_last;
  logic        cfg_acc;
  logic        cfg_sat;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_sum;
  logic        out_ovf;
  logic [7:0]  out_count;
  logic        busy;

  int tests;
  int fails;

  logic [23:0] pk_ops [8];

  rca_accum_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ops    (in_ops),
    .in_last   (in_last),
    .cfg_acc   (cfg_acc),
    .cfg_sat   (cfg_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] pack(input int a, input int b, input int c);
    return {c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL wait_idle: busy=%0b required 0", busy);
    end
  endtask

  // Drives pk_ops[0..n-1] back to back, last on the final beat,
  // and records the first result seen plus how many results came out.
  task automatic run_pkt(
    input  int          n,
    input  logic        acc,
    input  logic        sat,
    input  logic        flip,
    output logic        got,
    output logic [10:0] sum,
    output logic        ovf,
    output logic [7:0]  cnt,
    output int          nv,
    output int          lat
  );
    got = 1'b0;
    sum = '0;
    ovf = 1'b0;
    cnt = '0;
    nv  = 0;
    lat = -1;
    cfg_acc   = acc;
    cfg_sat   = sat;
    out_ready = 1'b1;
    for (int c = 0; c < n + 8; c++) begin
      @(negedge clk);
      if (out_valid) begin
        nv++;
        if (!got) begin
          got = 1'b1;
          sum = out_sum;
          ovf = out_ovf;
          cnt = out_count;
          lat = c - (n - 1);
        end
      end
      if (flip && c == 1) cfg_acc = !acc;
      if (c < n) begin
        in_valid = 1'b1;
        in_ops   = pk_ops[c];
        in_last  = (c == n - 1);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_in_ready: got %0b expected 0", in_ready);
    end
    tests++;
    if (out_valid !== 1'b0 || out_ovf !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_flags: valid=%0b ovf=%0b busy=%0b expected 0/0/0",
               out_valid, out_ovf, busy);
    end
    tests++;
    if (out_sum !== 11'd0 || out_count !== 8'd0) begin
      fails++;
      $display("FAIL rst_data: sum=%0d count=%0d expected 0/0",
               out_sum, out_count);
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_release_ready: got %0b expected 1", in_ready);
    end
  endtask

  task automatic test_sum_stream;
    logic [23:0] ops [5];
    logic [10:0] ev  [5];
    ops[0] = pack(1, 2, 3);       ev[0] = 11'd6;
    ops[1] = pack(255, 1, 0);     ev[1] = 11'd256;
    ops[2] = pack(255, 255, 255); ev[2] = 11'd765;
    ops[3] = pack(0, 0, 0);       ev[3] = 11'd0;
    ops[4] = pack(123, 45, 67);   ev[4] = 11'd235;
    wait_idle();
    cfg_acc   = 1'b0;
    cfg_sat   = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        tests++;
        if (out_valid !== 1'b0) begin
          fails++;
          $display("FAIL sum_latency: out_valid=%0b expected 0 one cycle after accept",
                   out_valid);
        end
      end
      if (c >= 2 && c <= 6) begin
        tests++;
        if (out_valid !== 1'b1 || out_sum !== ev[c-2] ||
            out_ovf !== 1'b0 || out_count !== 8'd1) begin
          fails++;
          $display("FAIL sum_out[%0d]: v=%0b sum=%0d ovf=%0b cnt=%0d expected 1/%0d/0/1",
                   c - 2, out_valid, out_sum, out_ovf, out_count, ev[c-2]);
        end
      end
      if (c == 7) begin
        tests++;
        if (out_valid !== 1'b0) begin
          fails++;
          $display("FAIL sum_drain: out_valid=%0b expected 0", out_valid);
        end
      end
      if (c < 5) begin
        in_valid = 1'b1;
        in_ops   = ops[c];
        in_last  = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
          fails++;
          $display("FAIL sum_in_ready[%0d]: got %0b expected 1", c, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_accum;
    logic got, ovf;
    logic [10:0] sum;
    logic [7:0] cnt;
    int nv, lat;
    wait_idle();
    pk_ops[0] = pack(1, 2, 3);
    pk_ops[1] = pack(10, 0, 0);
    pk_ops[2] = pack(4, 4, 4);
    run_pkt(3, 1'b1, 1'b0, 1'b0, got, sum, ovf, cnt, nv, lat);
    tests++;
    if (got !== 1'b1 || nv != 1) begin
      fails++;
      $display("FAIL acc_count_results: got=%0b results=%0d expected 1/1", got, nv);
    end
    tests++;
    if (sum !== 11'd28 || cnt !== 8'd3 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL acc_result: sum=%0d cnt=%0d ovf=%0b expected 28/3/0",
               sum, cnt, ovf);
    end
    tests++;
    if (lat != 2) begin
      fails++;
      $display("FAIL acc_latency: got %0d expected 2", lat);
    end
  endtask

  task automatic test_overflow;
    logic got, ovf;
    logic [10:0] sum;
    logic [7:0] cnt;
    int nv, lat;
    for (int i = 0; i < 3; i++) pk_ops[i] = pack(255, 255, 255);
    wait_idle();
    run_pkt(3, 1'b1, 1'b1, 1'b0, got, sum, ovf, cnt, nv, lat);
    tests++;
    if (got !== 1'b1 || sum !== 11'd2047 || ovf !== 1'b1 || cnt !== 8'd3) begin
      fails++;
      $display("FAIL ovf_sat: got=%0b sum=%0d ovf=%0b cnt=%0d expected 1/2047/1/3",
               got, sum, ovf, cnt);
    end
    wait_idle();
    run_pkt(3, 1'b1, 1'b0, 1'b0, got, sum, ovf, cnt, nv, lat);
    tests++;
    if (got !== 1'b1 || sum !== 11'd247 || ovf !== 1'b1 || cnt !== 8'd3) begin
      fails++;
      $display("FAIL ovf_wrap: got=%0b sum=%0d ovf=%0b cnt=%0d expected 1/247/1/3",
               got, sum, ovf, cnt);
    end
  endtask

  task automatic test_back_pressure;
    logic [10:0] ev [6];
    logic [10:0] held_v;
    logic held, saw_low;
    int tx, rx;
    for (int i = 0; i < 6; i++) ev[i] = 11'(11 + 2 * i);
    wait_idle();
    cfg_acc = 1'b0;
    cfg_sat = 1'b0;
    tx = 0;
    rx = 0;
    held = 1'b0;
    held_v = '0;
    saw_low = 1'b0;
    for (int c = 0; c < 40 && rx < 6; c++) begin
      @(negedge clk);
      if (held) begin
        tests++;
        if (out_valid !== 1'b1 || out_sum !== held_v) begin
          fails++;
          $display("FAIL bp_hold: v=%0b sum=%0d expected 1/%0d",
                   out_valid, out_sum, held_v);
        end
      end
      out_ready = !(c >= 2 && c <= 5);
      if (tx < 6) begin
        in_valid = 1'b1;
        in_ops   = pack(10 + tx, tx, 1);
        in_last  = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!in_ready) saw_low = 1'b1;
      held   = out_valid && !out_ready;
      held_v = out_sum;
      if (out_valid && out_ready) begin
        tests++;
        if (out_sum !== ev[rx]) begin
          fails++;
          $display("FAIL bp_order[%0d]: got %0d expected %0d", rx, out_sum, ev[rx]);
        end
        rx++;
      end
      if (in_valid && in_ready) tx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tests++;
    if (rx != 6 || tx != 6) begin
      fails++;
      $display("FAIL bp_complete: sent=%0d received=%0d expected 6/6", tx, rx);
    end
    tests++;
    if (saw_low !== 1'b1) begin
      fails++;
      $display("FAIL bp_in_ready_low: saw_low=%0b expected 1", saw_low);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_no_dup: out_valid=%0b expected 0", out_valid);
    end
  endtask

  task automatic test_cfg_change;
    logic got, ovf;
    logic [10:0] sum;
    logic [7:0] cnt;
    int nv, lat;
    wait_idle();
    pk_ops[0] = pack(1, 1, 1);
    pk_ops[1] = pack(2, 2, 2);
    pk_ops[2] = pack(3, 3, 3);
    run_pkt(3, 1'b1, 1'b0, 1'b1, got, sum, ovf, cnt, nv, lat);
    tests++;
    if (got !== 1'b1 || nv != 1 || sum !== 11'd18 || cnt !== 8'd3) begin
      fails++;
      $display("FAIL cfg_midpkt: got=%0b results=%0d sum=%0d cnt=%0d expected 1/1/18/3",
               got, nv, sum, cnt);
    end
    wait_idle();
    pk_ops[0] = pack(7, 0, 0);
    pk_ops[1] = pack(1, 1, 1);
    run_pkt(2, 1'b0, 1'b0, 1'b0, got, sum, ovf, cnt, nv, lat);
    tests++;
    if (got !== 1'b1 || nv != 2 || sum !== 11'd7 || cnt !== 8'd1) begin
      fails++;
      $display("FAIL cfg_new_mode: got=%0b results=%0d sum=%0d cnt=%0d expected 1/2/7/1",
               got, nv, sum, cnt);
    end
  endtask

  task automatic test_reset_mid;
    logic got, ovf;
    logic [10:0] sum;
    logic [7:0] cnt;
    int nv, lat;
    wait_idle();
    cfg_acc   = 1'b1;
    cfg_sat   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_ops   = pack(9, 9, 9);
    in_last  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_busy_before: got %0b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 ||
        out_sum !== 11'd0 || out_count !== 8'd0) begin
      fails++;
      $display("FAIL rstmid_async: busy=%0b v=%0b rdy=%0b sum=%0d cnt=%0d expected 0/0/0/0/0",
               busy, out_valid, in_ready, out_sum, out_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pk_ops[0] = pack(5, 5, 5);
    run_pkt(1, 1'b1, 1'b0, 1'b0, got, sum, ovf, cnt, nv, lat);
    tests++;
    if (got !== 1'b1 || sum !== 11'd15 || cnt !== 8'd1 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_new_pkt: got=%0b sum=%0d cnt=%0d ovf=%0b expected 1/15/1/0",
               got, sum, cnt, ovf);
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_ops    = '0;
    in_last   = 1'b0;
    cfg_acc   = 1'b0;
    cfg_sat   = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_sum_stream();
    test_accum();
    test_overflow();
    test_back_pressure();
    test_cfg_change();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rca_accum_pipe.md
# rca_accum_pipe

Parametrised, pipelined multi-operand adder with valid/ready handshakes and an optional packet-accumulate mode. Each input beat carries NUM_OPS unsigned operands; the block either emits one sum per beat or folds a packet of beats into a running sum with wrap or saturate overflow handling. It is the next generation of the team's 3×8-bit combinational adder: the same arithmetic, made streaming, back-pressurable and width/operand-count generic.

## Interface
- WIDTH, 8, operand width in bits
- NUM_OPS, 3, operands per beat (≥2)
- OUT_W, 11, result/accumulator width; elaboration error if OUT_W < WIDTH + $clog2(NUM_OPS)
- CNT_W, 8, beat-counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_ops  in  NUM_OPS*WIDTH  operand i at bits [i*WIDTH +: WIDTH], unsigned
- in_last  in  1  last beat of packet (ignored in sum mode)
- cfg_acc  in  1  0 = sum mode, 1 = accumulate mode
- cfg_sat  in  1  accumulate overflow: 0 = wrap, 1 = saturate
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid && out_ready
- out_sum  out  OUT_W  result
- out_ovf  out  1  packet overflowed OUT_W
- out_count  out  CNT_W  beats in result (saturates at 2^CNT_W−1)
- busy  out  1  s1_valid | out_valid | acc state RUN

## Operation
- Stage 1 (S1): on accept, register s1_sum = sum of NUM_OPS operands zero-extended to OUT_W (never overflows by the width check), plus in_last and the beat’s mode bits.
- Mode capture: a beat accepted while busy=0 takes cfg_acc/cfg_sat from the inputs and loads active-mode registers; beats accepted while busy=1 use the active registers. Config changes while busy=1 have no effect until idle.
- Stage 2 (S2) advances when s2_go = !out_valid || out_ready.
- Sum mode: S1 beat moves to output: out_sum = s1_sum, out_ovf=0, out_count=1, out_valid=1.
- Accumulate mode, state machine IDLE/RUN:
  - IDLE + beat: acc = s1_sum, cnt=1, ovf=0; in_last → load output, stay IDLE; else → RUN.
  - RUN + beat: t = acc + s1_sum in OUT_W+1 bits; carry → ovf=1, acc = sat ? all-ones : t[OUT_W-1:0]; cnt += 1 (saturating); in_last → output {acc, ovf, cnt}, → IDLE.
  - Non-last beats produce no output.
- out_* held stable while out_valid && !out_ready.
- in_ready = !s1_valid || s2_go (combinational from out_ready; accepted).
- Reset (any time, incl. mid-packet): all state cleared, partial packet discarded. Reset values: in_ready=0 while rst_n=0, then 1; out_valid=0, out_sum=0, out_ovf=0, out_count=0, busy=0; state IDLE.

## Timing
- Latency: beat accepted at edge k → out_valid high after edge k+1 (2 cycles), for sum-mode beats and last beats of a packet.
- Throughput: 1 beat/cycle with out_ready=1 in both modes; N-beat packet yields 1 result.
- Back-pressure: out_ready=0 with out_valid=1 stalls S2; S1 holds one beat; in_ready drops the cycle S1 is full and stalled.
- Simultaneous output consume and S1→S2 move in the same cycle: no bubble.

## Structure
- Package rca_pkg: acc_state_e {IDLE, RUN}; sat_add function (OUT_W+1 add with wrap/saturate, returns sum+carry); width-check constant.
- Sub-module rca_sum_stage: parametrised NUM_OPS×WIDTH → OUT_W combinational adder tree, instantiated in S1.
- Top holds S1 register, S2 accumulator/FSM, handshake logic.

## Test plan
- Sum mode, defaults, ops {1,2,3},{255,1,0},{255,255,255},{0,0,0},{123,45,67} back-to-back, out_ready=1 → out_sum 6,256,765,0,235 on consecutive cycles, 2-cycle latency, ovf=0, count=1.
- Accumulate, packet {1,2,3},{10,0,0},{4,4,4} last → single result 28, count=3, ovf=0; no intermediate out_valid.
- Overflow: three beats of {255,255,255} (2295) → cfg_sat=1: out_sum 2047, ovf=1; cfg_sat=0: out_sum 247, ovf=1.
- Back-pressure: sum-mode stream, out_ready low 4 cycles → out_sum held stable, in_ready low after S1 fills, no beat lost or duplicated, order preserved.
- Config change mid-packet: flip cfg_acc to 0 after first beat → packet still accumulated; next beat after idle uses new mode.
- Reset mid-packet: rst_n low after 2 of 3 beats → outputs zero asynchronously; new packet {5,5,5} last → 15, count=1.
